// File: rtl/vga_pkg.sv
// Shared types, timing constants and helpers for the sprite overlay engine.
package vga_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int H_COUNT_MAX = 799;
    localparam int V_COUNT_MAX = 524;

    // Field widths of the stored sprite record; the engine's width parameters default to these.
    localparam int POS_BITS = 10;
    localparam int VEL_W    = 4;
    localparam int RGB_W    = 12;

    typedef struct packed {
        logic [POS_BITS-1:0]     x;
        logic [POS_BITS-1:0]     y;
        logic signed [VEL_W-1:0] vx;
        logic signed [VEL_W-1:0] vy;
        logic [RGB_W-1:0]        rgb;
    } sprite_t;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } upd_state_t;

    // The most negative velocity has no positive twin, so it is pulled in by one.
    function automatic logic [VEL_W-1:0] clamp_vel(input logic [VEL_W-1:0] v);
        return (v == {1'b1, {(VEL_W-1){1'b0}}}) ? {1'b1, {(VEL_W-2){1'b0}}, 1'b1} : v;
    endfunction

endpackage

// File: rtl/vga_sprite_hit.sv
// Combinational test of whether the current pixel lies inside one square sprite.
module vga_sprite_hit #(
    parameter int H_BITS      = 10,
    parameter int V_BITS      = 10,
    parameter int SPRITE_SIZE = 8
) (
    input  logic [H_BITS-1:0] px,
    input  logic [V_BITS-1:0] py,
    input  logic [H_BITS-1:0] sx,
    input  logic [V_BITS-1:0] sy,
    output logic              hit
);

    logic [H_BITS:0] x_end;
    logic [V_BITS:0] y_end;

    assign x_end = {1'b0, sx} + (H_BITS+1)'(SPRITE_SIZE);
    assign y_end = {1'b0, sy} + (V_BITS+1)'(SPRITE_SIZE);

    assign hit = (px >= sx) && ({1'b0, px} < x_end) &&
                 (py >= sy) && ({1'b0, py} < y_end);

endmodule

// File: rtl/vga_sprite_engine.sv
// Multi-sprite overlay: bouncing sprites moved once per frame in blanking, composited
// over a background colour, with frame counting and overlap detection.
module vga_sprite_engine #(
    parameter int PIXEL_BITS  = 4,
    parameter int H_BITS      = 10,
    parameter int V_BITS      = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_SIZE = 8,
    parameter int VEL_BITS    = 4,
    localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [H_BITS-1:0]       vga_x,
    input  logic [V_BITS-1:0]       vga_y,
    input  logic                    vga_active,
    input  logic [3*PIXEL_BITS-1:0] bg_rgb,
    input  logic                    pause,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [VEL_BITS-1:0]     cfg_vx,
    input  logic [VEL_BITS-1:0]     cfg_vy,
    input  logic [3*PIXEL_BITS-1:0] cfg_rgb,
    output logic [PIXEL_BITS-1:0]   vga_r,
    output logic [PIXEL_BITS-1:0]   vga_g,
    output logic [PIXEL_BITS-1:0]   vga_b,
    output logic [15:0]             frame_count,
    output logic                    busy,
    output logic                    collision
);
    import vga_pkg::*;

    localparam logic signed [H_BITS+1:0] X_MAX = (H_BITS+2)'(H_ACTIVE - SPRITE_SIZE);
    localparam logic signed [V_BITS+1:0] Y_MAX = (V_BITS+2)'(V_ACTIVE - SPRITE_SIZE);

    sprite_t                   spr_q [NUM_SPRITES];
    sprite_t                   cur;
    sprite_t                   nxt;
    upd_state_t                state_q;
    upd_state_t                state_d;
    logic [IDX_W-1:0]          idx_q;
    logic                      blank_q;
    logic                      in_blank;
    logic                      tick;
    logic                      acc_q;
    logic                      multi_hit;
    logic                      any_hit;
    logic [NUM_SPRITES-1:0]    hit;
    logic [3*PIXEL_BITS-1:0]   pix;
    logic signed [H_BITS+1:0]  nx;
    logic signed [V_BITS+1:0]  ny;

    assign in_blank = (vga_y >= V_BITS'(V_ACTIVE));
    assign tick     = in_blank && !blank_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick && !pause) state_d = UPDATE;
            UPDATE:  if (idx_q == IDX_W'(NUM_SPRITES-1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == UPDATE);
    end

    // Bounce arithmetic for the sprite selected by idx_q.
    always_comb begin
        cur = spr_q[idx_q];
        nxt = cur;
        nx  = {2'b00, cur.x} + {{(H_BITS+2-VEL_BITS){cur.vx[VEL_BITS-1]}}, cur.vx};
        ny  = {2'b00, cur.y} + {{(V_BITS+2-VEL_BITS){cur.vy[VEL_BITS-1]}}, cur.vy};
        if (nx[H_BITS+1]) begin
            nxt.x  = '0;
            nxt.vx = -cur.vx;
        end else if (nx > X_MAX) begin
            nxt.x  = X_MAX[H_BITS-1:0];
            nxt.vx = -cur.vx;
        end else begin
            nxt.x  = nx[H_BITS-1:0];
        end
        if (ny[V_BITS+1]) begin
            nxt.y  = '0;
            nxt.vy = -cur.vy;
        end else if (ny > Y_MAX) begin
            nxt.y  = Y_MAX[V_BITS-1:0];
            nxt.vy = -cur.vy;
        end else begin
            nxt.y  = ny[V_BITS-1:0];
        end
    end

    // Config is written after the FSM so its velocity wins a same-sprite conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            blank_q     <= 1'b1;
            frame_count <= '0;
            collision   <= 1'b0;
            acc_q       <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                spr_q[i].x   <= POS_BITS'(i * 2 * SPRITE_SIZE);
                spr_q[i].y   <= '0;
                spr_q[i].vx  <= VEL_W'(1);
                spr_q[i].vy  <= VEL_W'(1);
                spr_q[i].rgb <= '1;
            end
        end else begin
            blank_q <= in_blank;
            if (tick) begin
                frame_count <= frame_count + 16'd1;
                collision   <= acc_q;
                acc_q       <= 1'b0;
            end else if (multi_hit) begin
                acc_q <= 1'b1;
            end
            if (state_q == UPDATE) begin
                spr_q[idx_q] <= nxt;
                idx_q        <= (state_d == IDLE) ? '0 : idx_q + IDX_W'(1);
            end
            if (cfg_we && (int'(cfg_idx) < NUM_SPRITES)) begin
                spr_q[cfg_idx].vx  <= clamp_vel(cfg_vx);
                spr_q[cfg_idx].vy  <= clamp_vel(cfg_vy);
                spr_q[cfg_idx].rgb <= cfg_rgb;
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        vga_sprite_hit #(
            .H_BITS      (H_BITS),
            .V_BITS      (V_BITS),
            .SPRITE_SIZE (SPRITE_SIZE)
        ) u_hit (
            .px  (vga_x),
            .py  (vga_y),
            .sx  (spr_q[g].x),
            .sy  (spr_q[g].y),
            .hit (hit[g])
        );
    end

    always_comb begin
        pix       = bg_rgb;
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (hit[i]) begin
                if (!any_hit) pix = spr_q[i].rgb;
                else          multi_hit = 1'b1;
                any_hit = 1'b1;
            end
        end
        if (!vga_active) begin
            pix       = '0;
            multi_hit = 1'b0;
        end
    end

    assign vga_r = pix[3*PIXEL_BITS-1:2*PIXEL_BITS];
    assign vga_g = pix[2*PIXEL_BITS-1:PIXEL_BITS];
    assign vga_b = pix[PIXEL_BITS-1:0];

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor compares them.
module tb_vga_sprite_engine;

    localparam int N = 4, SZ = 8, XMAX = 632, YMAX = 472;
    localparam int K_PIX = 0, K_FRAME = 1, K_BUSY = 2, K_COLL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  vga_x, vga_y;
    logic        vga_active;
    logic [11:0] bg_rgb;
    logic        pause, cfg_we;
    logic [1:0]  cfg_idx;
    logic [3:0]  cfg_vx, cfg_vy;
    logic [11:0] cfg_rgb;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [15:0] frame_count;
    logic        busy, collision;

    vga_sprite_engine dut (
        .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .vga_active(vga_active),
        .bg_rgb(bg_rgb), .pause(pause), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .cfg_rgb(cfg_rgb),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_count(frame_count), .busy(busy), .collision(collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int exp;
        int x;
        int y;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0, n_fail = 0;
    int   mx[N], my[N], mvx[N], mvy[N], mrgb[N];
    int   mframe, mcoll, macc, mbg;

    function automatic string kname(int k);
        case (k)
            K_PIX:   return "pixel";
            K_FRAME: return "frame_count";
            K_BUSY:  return "busy";
            default: return "collision";
        endcase
    endfunction

    function automatic void push_exp(int kind, int e, int x = 0, int y = 0);
        chk_t c;
        c.kind = kind; c.exp = e; c.x = x; c.y = y;
        q.push_back(c);
    endfunction

    initial begin
        chk_t c;
        int   act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                c = q.pop_front();
                case (c.kind)
                    K_PIX:   act = int'({vga_r, vga_g, vga_b});
                    K_FRAME: act = int'(frame_count);
                    K_BUSY:  act = int'(busy);
                    default: act = int'(collision);
                endcase
                n_tests++;
                if (act != c.exp) begin
                    n_fail++;
                    $display("FAIL %s @(%0d,%0d) t=%0t: got 0x%0h expected 0x%0h",
                             kname(c.kind), c.x, c.y, $time, act, c.exp);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int clampv(int v);
        return (v == -8) ? -7 : v;
    endfunction

    task automatic move(input int p, input int v, input int lim, output int np, output int nv);
        int n;
        n  = p + v;
        np = n;
        nv = v;
        if (n < 0)        begin np = 0;   nv = -v; end
        else if (n > lim) begin np = lim; nv = -v; end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = i * 2 * SZ; my[i] = 0; mvx[i] = 1; mvy[i] = 1; mrgb[i] = 12'hFFF;
        end
        mframe = 0; mcoll = 0; macc = 0;
    endfunction

    task automatic model_tick(input bit motion);
        mframe = (mframe + 1) & 16'hFFFF;
        mcoll  = macc;
        macc   = 0;
        if (motion)
            for (int i = 0; i < N; i++) begin
                move(mx[i], mvx[i], XMAX, mx[i], mvx[i]);
                move(my[i], mvy[i], YMAX, my[i], mvy[i]);
            end
    endtask

    function automatic int n_hits(int x, int y);
        int n = 0;
        for (int i = 0; i < N; i++)
            if (x >= mx[i] && x < mx[i] + SZ && y >= my[i] && y < my[i] + SZ) n++;
        return n;
    endfunction

    function automatic int model_pix(int x, int y, bit act);
        if (!act) return 0;
        for (int i = 0; i < N; i++)
            if (x >= mx[i] && x < mx[i] + SZ && y >= my[i] && y < my[i] + SZ) return mrgb[i];
        return mbg;
    endfunction

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(int x, int y, bit act);
        vga_x = 10'(x); vga_y = 10'(y); vga_active = act;
        push_exp(K_PIX, model_pix(x, y, act), x, y);
        if (act && n_hits(x, y) >= 2) macc = 1;
        step();
    endtask

    task automatic probe_sprites();
        for (int i = 0; i < N; i++) begin
            probe(mx[i], my[i], 1'b1);
            probe(mx[i] + SZ - 1, my[i] + SZ - 1, 1'b1);
            if (mx[i] > 0)       probe(mx[i] - 1, my[i], 1'b1);
            if (mx[i] + SZ < 640) probe(mx[i] + SZ, my[i], 1'b1);
            if (my[i] + SZ < 480) probe(mx[i], my[i] + SZ, 1'b1);
        end
        vga_active = 1'b0; vga_y = '0;
    endtask

    task automatic cfg(int idx, int vx, int vy, int rgb);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_vx = vx[3:0]; cfg_vy = vy[3:0]; cfg_rgb = 12'(rgb);
        step();
        cfg_we = 1'b0;
        mvx[idx] = clampv(vx); mvy[idx] = clampv(vy); mrgb[idx] = rgb;
    endtask

    task automatic do_frame(int nsamp, bit conf = 1'b0, int cvx = 0, int cvy = 0, int crgb = 0);
        int x, y, i;
        mbg = int'($urandom_range(0, 4095));
        bg_rgb = 12'(mbg);
        for (int s = 0; s < nsamp; s++) begin
            if ($urandom_range(0, 1) == 1) begin
                i = int'($urandom_range(0, N - 1));
                x = mx[i] + int'($urandom_range(0, SZ + 3)) - 2;
                y = my[i] + int'($urandom_range(0, SZ + 3)) - 2;
            end else begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end
            if (x < 0) x = 0;
            if (x > 639) x = 639;
            if (y < 0) y = 0;
            if (y > 479) y = 479;
            probe(x, y, $urandom_range(0, 7) != 0);
        end
        vga_active = 1'b0; vga_x = '0; vga_y = 10'd480;
        step();
        model_tick(!pause);
        push_exp(K_FRAME, mframe);
        push_exp(K_COLL, mcoll);
        if (!pause)
            for (int k = 0; k < N; k++) begin
                push_exp(K_BUSY, 1, k);
                if (k == 0 && conf) begin
                    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_vx = cvx[3:0]; cfg_vy = cvy[3:0];
                    cfg_rgb = 12'(crgb);
                end
                step();
                if (k == 0 && conf) begin
                    cfg_we = 1'b0;
                    mvx[0] = clampv(cvx); mvy[0] = clampv(cvy); mrgb[0] = crgb;
                end
            end
        push_exp(K_BUSY, 0);
        step();
        vga_y = '0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; vga_x = '0; vga_y = 10'd500; vga_active = 1'b0; bg_rgb = '0;
        pause = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_vx = '0; cfg_vy = '0; cfg_rgb = '0;
        mbg = 0;
        step();
        do_reset();
        n_tests++;
        if (frame_count !== 16'd0 || busy !== 1'b0 || collision !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state: frame_count=%0d busy=%0b collision=%0b",
                     frame_count, busy, collision);
        end
        push_exp(K_FRAME, 0); push_exp(K_BUSY, 0); push_exp(K_COLL, 0);
        step();
        step();
        push_exp(K_FRAME, 0); push_exp(K_BUSY, 0);
        step();
        vga_y = '0;
        step();
        probe_sprites();

        // first frame: sprite 1 lands at (17,1)
        do_frame(6);
        probe(17, 1, 1'b1);
        n_tests++;
        if ({vga_r, vga_g, vga_b} !== 12'hFFF || frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL first frame: pixel(17,1)=0x%0h frame_count=%0d",
                     {vga_r, vga_g, vga_b}, frame_count);
        end
        probe(17, 1, 1'b0);
        probe_sprites();

        // sprites 0 and 2 converge; overlap shows sprite 0
        cfg(0, 4, 0, 12'hF00);
        cfg(2, -4, 0, 12'h0F0);
        cfg(1, 7, 7, 12'h00F);
        for (int f = 0; f < 4; f++) do_frame(0);
        probe(mx[0] + 3, my[0] + 2, 1'b1);
        do_frame(0);
        do_frame(0);
        probe_sprites();

        // paused frames count but do not move
        pause = 1'b1;
        for (int f = 0; f < 3; f++) do_frame(4);
        pause = 1'b0;
        probe_sprites();

        // cfg write colliding with the FSM write-back of sprite 0
        do_frame(4, 1'b1, -3, 2, 12'hABC);
        probe_sprites();

        // right-edge bounce, then saturated negative velocity to the left edge
        do_reset();
        vga_y = '0;
        step();
        cfg(0, 7, 0, 12'h123);
        for (int f = 0; f < 90; f++) do_frame(2);
        probe_sprites();
        cfg(0, 5, 0, 12'h456);
        do_frame(2);
        probe_sprites();
        do_frame(2);
        probe_sprites();
        cfg(0, -8, 0, 12'h789);
        for (int f = 0; f < 90; f++) do_frame(1);
        probe_sprites();
        do_frame(2);
        probe_sprites();

        // vertical bounces at bottom and top
        cfg(1, 0, 7, 12'h0AA);
        cfg(3, 1, -7, 12'hA0A);
        for (int f = 0; f < 45; f++) do_frame(2);
        probe_sprites();

        // reset while the update is on sprite 2
        vga_y = 10'd480;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset mid-update: busy=%0b frame_count=%0d", busy, frame_count);
        end
        push_exp(K_BUSY, 0); push_exp(K_FRAME, 0); push_exp(K_COLL, 0);
        model_reset();
        rst = 1'b0;
        vga_y = '0;
        step();
        probe_sprites();
        do_frame(4);
        probe_sprites();

        step();
        step();
        if (n_tests < 12) begin
            n_fail++;
            $display("FAIL only %0d checks executed", n_tests);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_fail != 0) $display("TEST FAILED");
        else             $display("TEST PASSED");
        $finish;
    end

endmodule
